// File: rtl/switch_rr.sv
// switch_rr: three-port (top/bottom/right) NoC switch with FWFT input FIFOs,
// range-based destination routing and a round-robin arbiter per output.
// Optional feature: define SWITCH_PKT_LOCK_EN to hold an output's arbitration
// on one input from a packet's first flit until its last flit.
module switch_rr #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 8,
  parameter int FifoDepth = 4,
  parameter int TopMin    = 1,
  parameter int TopMax    = 1,
  parameter int BottomMin = 0,
  parameter int BottomMax = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DataWidth-1:0] i_data1,
  input  logic                 i_last1,
  input  logic                 i_data_valid1,
  output logic                 o_data_ready1,
  input  logic [DataWidth-1:0] i_data2,
  input  logic                 i_last2,
  input  logic                 i_data_valid2,
  output logic                 o_data_ready2,
  input  logic [DataWidth-1:0] i_data3,
  input  logic                 i_last3,
  input  logic                 i_data_valid3,
  output logic                 o_data_ready3,
  output logic [DataWidth-1:0] o_data1,
  output logic                 o_last1,
  output logic                 o_data_valid1,
  input  logic                 i_data_ready1,
  output logic [DataWidth-1:0] o_data2,
  output logic                 o_last2,
  output logic                 o_data_valid2,
  input  logic                 i_data_ready2,
  output logic [DataWidth-1:0] o_data3,
  output logic                 o_last3,
  output logic                 o_data_valid3,
  input  logic                 i_data_ready3
);
  localparam logic [AddrWidth-1:0] TOP_LO = AddrWidth'(TopMin);
  localparam logic [AddrWidth-1:0] TOP_HI = AddrWidth'(TopMax);
  localparam logic [AddrWidth-1:0] BOT_LO = AddrWidth'(BottomMin);
  localparam logic [AddrWidth-1:0] BOT_HI = AddrWidth'(BottomMax);

  // Index 0/1/2 = port 1 (top) / 2 (bottom) / 3 (right) on both sides.
  logic [2:0][DataWidth-1:0] in_data, head_data, out_data;
  logic [2:0]                in_last, in_valid, in_ready;
  logic [2:0]                head_last, head_valid, pop;
  logic [2:0]                out_last, out_valid, out_ready;
  logic [2:0][1:0]           route;
  logic [2:0][2:0]           gnt_all;

  assign in_data   = {i_data3, i_data2, i_data1};
  assign in_last   = {i_last3, i_last2, i_last1};
  assign in_valid  = {i_data_valid3, i_data_valid2, i_data_valid1};
  assign out_ready = {i_data_ready3, i_data_ready2, i_data_ready1};
  assign {o_data_ready3, o_data_ready2, o_data_ready1} = in_ready;
  assign o_data1 = out_data[0];
  assign o_data2 = out_data[1];
  assign o_data3 = out_data[2];
  assign {o_last3, o_last2, o_last1} = out_last;
  assign {o_data_valid3, o_data_valid2, o_data_valid1} = out_valid;

  // Inclusive range test via borrow bits, so a zero lower bound needs no special case.
  function automatic logic in_range(input logic [AddrWidth-1:0] d,
                                    input logic [AddrWidth-1:0] lo,
                                    input logic [AddrWidth-1:0] hi);
    logic [AddrWidth:0] dl, dh;
    dl = {1'b0, d} - {1'b0, lo};
    dh = {1'b0, hi} - {1'b0, d};
    return ~dl[AddrWidth] & ~dh[AddrWidth];
  endfunction

  // Cyclic successor over input numbers 1..3.
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd3) ? 2'd1 : p + 2'd1;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_in
    logic [AddrWidth-1:0] dest;

    switch_rr_fifo #(.DataWidth(DataWidth), .FifoDepth(FifoDepth)) u_fifo (
      .clk       (i_clk),
      .reset     (i_reset),
      .in_data   (in_data[k]),
      .in_last   (in_last[k]),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .pop       (pop[k]),
      .head_data (head_data[k]),
      .head_last (head_last[k]),
      .head_valid(head_valid[k])
    );

    assign dest     = head_data[k][DataWidth-1 -: AddrWidth];
    // Top wins over bottom when ranges overlap; everything else goes right.
    assign route[k] = in_range(dest, TOP_LO, TOP_HI) ? 2'd0 :
                      in_range(dest, BOT_LO, BOT_HI) ? 2'd1 : 2'd2;
    // A head routes to exactly one output, so at most one grant lands here.
    assign pop[k]   = gnt_all[0][k] | gnt_all[1][k] | gnt_all[2][k];
  end

  for (genvar o = 0; o < 3; o++) begin : g_out
    logic [2:0]           cand, gnt;
    logic [1:0]           ptr, s1, s2, gnt_num, gidx;
    logic                 accept, xfer, vld, lst;
    logic [DataWidth-1:0] dat;
`ifdef SWITCH_PKT_LOCK_EN
    logic                 locked;
    logic [1:0]           lock_idx;
`endif

    // Inputs whose head wants this output (restricted to the owner while locked).
    always_comb begin
      for (int k = 0; k < 3; k++) cand[k] = head_valid[k] & (route[k] == 2'(o));
`ifdef SWITCH_PKT_LOCK_EN
      if (locked) cand = cand & (3'b001 << lock_idx);
`endif
    end

    assign s1 = nxt(ptr);
    assign s2 = nxt(s1);

    // Round-robin pick: search from the input after the last winner.
    always_comb begin
      gnt_num = 2'd0;
      if (cand[s1 - 2'd1])       gnt_num = s1;
      else if (cand[s2 - 2'd1])  gnt_num = s2;
      else if (cand[ptr - 2'd1]) gnt_num = ptr;
    end

    assign accept     = ~vld | out_ready[o];
    assign xfer       = accept & (gnt_num != 2'd0);
    assign gidx       = (gnt_num == 2'd0) ? 2'd0 : gnt_num - 2'd1;
    assign gnt        = xfer ? (3'b001 << gidx) : 3'b000;
    assign gnt_all[o] = gnt;

    // Output register: refill on grant, otherwise drop valid once drained.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        vld <= 1'b0;
        dat <= '0;
        lst <= 1'b0;
        ptr <= 2'd3;
`ifdef SWITCH_PKT_LOCK_EN
        locked   <= 1'b0;
        lock_idx <= 2'd0;
`endif
      end else if (xfer) begin
        vld <= 1'b1;
        dat <= head_data[gidx];
        lst <= head_last[gidx];
        ptr <= gnt_num;
`ifdef SWITCH_PKT_LOCK_EN
        locked   <= ~head_last[gidx];
        lock_idx <= gidx;
`endif
      end else if (out_ready[o]) begin
        vld <= 1'b0;
      end
    end

    assign out_valid[o] = vld;
    assign out_data[o]  = dat;
    assign out_last[o]  = lst;
  end
endmodule

// First-word-fall-through input FIFO; readiness ignores a same-cycle pop.
module switch_rr_fifo #(
  parameter int DataWidth = 32,
  parameter int FifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 pop,
  output logic [DataWidth-1:0] head_data,
  output logic                 head_last,
  output logic                 head_valid
);
  localparam int PW = $clog2(FifoDepth);
  localparam int CW = PW + 1;

  logic [DataWidth:0] mem [FifoDepth];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count;
  logic               push;

  assign in_ready   = ~reset & (count != CW'(FifoDepth));
  assign push       = in_valid & in_ready;
  assign head_valid = (count != '0);
  assign {head_last, head_data} = mem[rd_ptr];

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule
